// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared bus widths, zero word and default depth for the instruction queue
package inst_queue_pkg;
    localparam int IQ_ADDR_W = 32;
    localparam int IQ_INST_W = 32;
    localparam int IQ_DEPTH  = 4;
    localparam logic [63:0] IQ_ZERO_WORD = '0;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: IF-to-ID circular instruction buffer with flush and one-cycle latency
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int ADDR_W = IQ_ADDR_W,
    parameter int INST_W = IQ_INST_W,
    parameter int DEPTH  = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic full, empty, push, pop;
    always_comb begin
        full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty    = wr_ptr == rd_ptr;
        if_ready = !full;
        id_valid = !empty;
        push     = if_valid && !full;
        pop      = id_ready && !empty;
        count    = wr_ptr - rd_ptr;
        id_pc    = empty ? IQ_ZERO_WORD[ADDR_W-1:0] : pc_mem[rd_ptr[AW-1:0]];
        id_inst  = empty ? IQ_ZERO_WORD[INST_W-1:0] : inst_mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage is intentionally not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            pc_mem[wr_ptr[AW-1:0]]   <= if_pc;
            inst_mem[wr_ptr[AW-1:0]] <= if_inst;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized and directed checks of inst_queue against a queue-based model
module tb_inst_queue;
    localparam int DEPTH = 4;
    logic        clk = 0;
    logic        rst = 0;
    logic        flush = 0;
    logic        if_valid = 0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        id_valid;
    logic        id_ready = 0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;
    int errors = 0;
    int checks = 0;
    logic [63:0] model_q[$];

    inst_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic r);
        if_valid = v;
        if_pc    = pc;
        if_inst  = $urandom;
        id_ready = r;
    endtask

    // compare all outputs with the model, then advance one edge and update the model
    task automatic cyc();
        int  sz;
        bit  do_push, do_pop;
        logic [63:0] ent;
        sz = model_q.size();
        check("id_valid", id_valid, sz != 0);
        check("if_ready", if_ready, sz < DEPTH);
        check("count", count, sz);
        check("id_pc", id_pc, sz != 0 ? model_q[0][63:32] : 0);
        check("id_inst", id_inst, sz != 0 ? model_q[0][31:0] : 0);
        do_push = if_valid && sz < DEPTH;
        do_pop  = id_ready && sz != 0;
        ent = {if_pc, if_inst};
        @(posedge clk);
        #1;
        if (!rst || flush) model_q.delete();
        else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(ent);
        end
    endtask

    initial begin
        rst = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        cyc();
        // fill to full without consuming
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(i * 4), 0);
            cyc();
        end
        set_in(0, 0, 0);
        check("fill_count", count, 4);
        check("fill_if_ready", if_ready, 0);
        check("fill_id_pc", id_pc, 0);
        // full queue rejects push even with a simultaneous pop
        set_in(1, 32'h10, 1);
        cyc();
        set_in(0, 0, 0);
        check("fullpop_count", count, 3);
        check("fullpop_id_pc", id_pc, 4);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1);
            cyc();
        end
        // streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            set_in(1, 32'h100 + 32'(i * 4), 1);
            if (i > 0) begin
                check("stream_count", count, 1);
                check("stream_id_pc", id_pc, 32'h100 + 32'((i - 1) * 4));
            end
            cyc();
        end
        set_in(0, 0, 1);
        cyc();
        // flush wins over a simultaneous push
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h20 + 32'(i * 4), 0);
            cyc();
        end
        set_in(1, 32'h40, 0);
        flush = 1;
        check("flush_prevalid", id_valid, 1);
        cyc();
        flush = 0;
        set_in(0, 0, 0);
        check("flush_count", count, 0);
        check("flush_id_valid", id_valid, 0);
        check("flush_id_inst", id_inst, 0);
        // pop on empty is ignored
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1);
            cyc();
        end
        check("emptypop_valid", id_valid, 0);
        check("emptypop_count", count, 0);
        set_in(1, 32'h80, 0);
        cyc();
        set_in(0, 0, 0);
        check("after_empty_pc", id_pc, 32'h80);
        // reset during a push with two entries queued
        set_in(1, 32'h84, 0);
        cyc();
        set_in(1, 32'h88, 0);
        rst = 0;
        cyc();
        rst = 1;
        set_in(0, 0, 0);
        check("midrst_count", count, 0);
        check("midrst_if_ready", if_ready, 1);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
            flush = $urandom_range(0, 15) == 0;
            rst   = $urandom_range(0, 63) != 0;
            cyc();
        end
        rst = 1;
        flush = 0;
        set_in(0, 0, 0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
